// File: rtl/acc_rd_pkg.sv
// Shared types and constants for the IFM read-side scatter path.
package acc_rd_pkg;

  localparam int WORD_BITS = 512;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    FIN
  } state_t;

  // Lane index width; a single lane still needs a 1-bit select.
  function automatic int lane_idx_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/ifm_scatter_if.sv
// Read-master request/response and beat-stream bundle.
// master: the scatter block (issues requests, sinks the stream).
// slave:  the read master (serves requests, sources the stream).
interface ifm_scatter_if;
  import acc_rd_pkg::*;

  logic                 rmst_req;
  logic [63:0]          rmst_addr;
  logic [63:0]          rmst_xfer_size;
  logic                 rmst_done;
  logic [WORD_BITS-1:0] tdata;
  logic                 valid;
  logic                 ready;

  modport master (
    output rmst_req, rmst_addr, rmst_xfer_size, ready,
    input  rmst_done, tdata, valid
  );

  modport slave (
    input  rmst_req, rmst_addr, rmst_xfer_size, ready,
    output rmst_done, tdata, valid
  );

endinterface

// File: rtl/ifm_lane_reg.sv
// One-entry holding register feeding a single IFM input buffer lane.
// A word stays until the lane accepts it; a load in the same cycle as a
// pop replaces the word and keeps the lane full.
module ifm_lane_reg
  import acc_rd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] load_data,
  output logic [WORD_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready
);

  // Occupancy: load has priority over pop so push+pop stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)     valid <= 1'b0;
    else if (load)  valid <= 1'b1;
    else if (ready) valid <= 1'b0;
  end

  // Payload capture on load.
  always_ff @(posedge clk) begin
    // NOTE: the wide payload is not reset; valid alone qualifies it.
    if (load) data <= load_data;
  end

endmodule

// File: rtl/ifm_scatter.sv
// Read-side scatter: issues burst read requests, accepts the 512-bit beat
// stream and distributes beats round-robin over NUM_PORTS lane registers.
module ifm_scatter
  import acc_rd_pkg::*;
#(
  parameter int WORD_BYTE   = 64,
  parameter int NUM_PORTS   = 28,
  parameter int BURST_WORDS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [63:0]                    rmst_offset,
  input  logic [31:0]                    total_words,
  output logic                           busy,
  output logic                           job_done,
  ifm_scatter_if.master                  rd,
  output logic [NUM_PORTS*WORD_BITS-1:0] lane_data,
  output logic [NUM_PORTS-1:0]           lane_valid,
  input  logic [NUM_PORTS-1:0]           lane_ready
);

  localparam int          LANE_W       = lane_idx_w(NUM_PORTS);
  localparam int          BL_W         = $clog2(BURST_WORDS + 1);
  localparam logic [63:0] WORD_BYTE_64 = 64'(WORD_BYTE);

  state_t            state;
  logic [63:0]       offset;
  logic [31:0]       word_cnt;
  logic [31:0]       remaining;
  logic [BL_W-1:0]   burst_left;
  logic [LANE_W-1:0] lane_sel;
  logic              done_seen;
  logic              accept;

  // Beats in the next burst: min(BURST_WORDS, words still to fetch).
  function automatic logic [BL_W-1:0] burst_len(input logic [31:0] rem);
    return (rem >= 32'(BURST_WORDS)) ? BL_W'(BURST_WORDS) : BL_W'(rem);
  endfunction

  assign busy = (state != IDLE);

  // Ready looks only at the target lane, never at valid.
  assign rd.ready = (state == XFER) && (burst_left != '0) &&
                    (!lane_valid[lane_sel] || lane_ready[lane_sel]);
  assign accept   = rd.valid && rd.ready;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    ifm_lane_reg u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept && (lane_sel == LANE_W'(i))),
      .load_data (rd.tdata),
      .data      (lane_data[i*WORD_BITS +: WORD_BITS]),
      .valid     (lane_valid[i]),
      .ready     (lane_ready[i])
    );
  end

  // Job FSM with counters and registered request/address/size outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      offset            <= '0;
      word_cnt          <= '0;
      remaining         <= '0;
      burst_left        <= '0;
      lane_sel          <= '0;
      done_seen         <= 1'b0;
      job_done          <= 1'b0;
      rd.rmst_req       <= 1'b0;
      rd.rmst_addr      <= '0;
      rd.rmst_xfer_size <= '0;
    end else begin
      rd.rmst_req <= 1'b0;
      job_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            offset    <= rmst_offset;
            word_cnt  <= '0;
            remaining <= total_words;
            lane_sel  <= '0;
            if (total_words != '0) begin
              state             <= REQ;
              rd.rmst_req       <= 1'b1;
              rd.rmst_addr      <= rmst_offset;
              rd.rmst_xfer_size <= 64'(burst_len(total_words)) * WORD_BYTE_64;
            end else begin
              state    <= FIN;
              job_done <= 1'b1;
            end
          end
        end
        REQ: begin
          burst_left <= burst_len(remaining);
          done_seen  <= 1'b0;
          state      <= XFER;
        end
        XFER: begin
          if (rd.rmst_done) done_seen <= 1'b1;
          if (accept) begin
            word_cnt   <= word_cnt + 32'd1;
            remaining  <= remaining - 32'd1;
            burst_left <= burst_left - BL_W'(1);
            lane_sel   <= (lane_sel == LANE_W'(NUM_PORTS - 1)) ? '0 : lane_sel + LANE_W'(1);
          end
          // The burst closes once all its beats are in and the read master
          // has reported completion, in either order.
          if ((burst_left == '0) && (done_seen || rd.rmst_done)) begin
            if (remaining == '0) begin
              state    <= FIN;
              job_done <= 1'b1;
            end else begin
              state             <= REQ;
              rd.rmst_req       <= 1'b1;
              rd.rmst_addr      <= offset + {32'b0, word_cnt} * WORD_BYTE_64;
              rd.rmst_xfer_size <= 64'(burst_len(remaining)) * WORD_BYTE_64;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_scatter.sv
// Self-checking bench for ifm_scatter: a behavioural read master serves
// bursts from an address-derived memory image, lane consumers pop with
// random back-pressure, and each job is scored against the expected
// request list and beat-to-lane mapping derived from the job parameters.
module tb_ifm_scatter;
  import acc_rd_pkg::*;

  localparam int NP = 28;
  localparam int WB = 64;
  localparam int BW = 2;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] size;
  } req_t;

  typedef struct {
    int             lane;
    logic [511:0]   data;
  } pop_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [63:0]         rmst_offset = '0;
  logic [31:0]         total_words = '0;
  logic                busy;
  logic                job_done;
  logic [NP*512-1:0]   lane_data;
  logic [NP-1:0]       lane_valid;
  logic [NP-1:0]       lane_ready;

  ifm_scatter_if rd();

  ifm_scatter #(.WORD_BYTE(WB), .NUM_PORTS(NP), .BURST_WORDS(BW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rmst_offset (rmst_offset),
    .total_words (total_words),
    .busy        (busy),
    .job_done    (job_done),
    .rd          (rd),
    .lane_data   (lane_data),
    .lane_valid  (lane_valid),
    .lane_ready  (lane_ready)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          rand_mode = 0;
  logic [NP-1:0] hold_mask = '0;
  int          done_mode_seq[$];
  req_t        obs_req[$];
  pop_t        obs_pop[$];
  int          obs_beats = 0;
  int          obs_done = 0;
  int          addr_unstable = 0;
  logic [63:0] exp_off = '0;
  int          exp_total = 0;
  logic [63:0] salt = '0;
  string       diag;

  // Memory image: each 64-byte word is a distinct function of its address.
  function automatic logic [511:0] data_at(input logic [63:0] a);
    logic [511:0] d;
    for (int j = 0; j < 8; j++) d[j*64 +: 64] = (a ^ salt) * 64'h9E37_79B9_7F4A_7C15 + 64'(j);
    return d;
  endfunction

  // Expected requests: one per BW-word chunk of the job.
  function automatic int req_errors();
    int err = 0;
    int n_exp = (exp_total + BW - 1) / BW;
    logic [63:0] ea, es;
    diag = "";
    foreach (obs_req[j]) begin
      int k = j * BW;
      int len = (exp_total - k < BW) ? exp_total - k : BW;
      ea = exp_off + 64'(k) * 64'd64;
      es = 64'(len) * 64'd64;
      if (j >= n_exp || obs_req[j].addr !== ea || obs_req[j].size !== es) begin
        if (err == 0) diag = $sformatf("req %0d got addr %h size %0d, want addr %h size %0d",
                                       j, obs_req[j].addr, obs_req[j].size, ea, es);
        err++;
      end
    end
    if (obs_req.size() != n_exp) begin
      if (err == 0) diag = $sformatf("got %0d requests, want %0d", obs_req.size(), n_exp);
      err++;
    end
    return err;
  endfunction

  // Beat k belongs to lane k mod NP; the n-th pop of lane l must be beat l + n*NP.
  function automatic int lane_errors();
    int err = 0;
    int ptr[NP];
    diag = "";
    foreach (ptr[i]) ptr[i] = 0;
    foreach (obs_pop[j]) begin
      int l = obs_pop[j].lane;
      int k = l + ptr[l] * NP;
      logic [511:0] want = data_at(exp_off + 64'(k) * 64'd64);
      ptr[l]++;
      if (k >= exp_total || obs_pop[j].data !== want) begin
        if (err == 0) diag = $sformatf("pop %0d lane %0d beat %0d got %h want %h (low 64b)",
                                       j, l, k, obs_pop[j].data[63:0], want[63:0]);
        err++;
      end
    end
    if (obs_pop.size() != exp_total) begin
      if (err == 0) diag = $sformatf("got %0d lane pops, want %0d", obs_pop.size(), exp_total);
      err++;
    end
    return err;
  endfunction

  // Read master + lane consumers + event recorder, one step per cycle.
  task automatic bus_model();
    logic [63:0] b_addr = '0;
    int b_len = 0, b_sent = 0, b_mode = 0, b_delay = 0;
    bit b_act = 0, b_done = 0;
    logic [63:0] p_addr[$];
    int p_len[$];
    int p_mode[$];
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b_act = 0;
        p_addr.delete(); p_len.delete(); p_mode.delete();
        rd.valid = 1'b0;
        rd.rmst_done = 1'b0;
        continue;
      end
      for (int i = 0; i < NP; i++)
        lane_ready[i] = hold_mask[i] ? 1'b0 : (rand_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!b_act && p_len.size() > 0) begin
        b_act = 1;
        b_addr = p_addr.pop_front();
        b_len = p_len.pop_front();
        b_mode = p_mode.pop_front();
        b_sent = 0;
        b_done = 0;
        b_delay = (rand_mode == 0) ? 0 : int'($urandom_range(0, 3));
      end
      rd.valid = 1'b0;
      rd.rmst_done = 1'b0;
      if (b_act) begin
        if (b_sent < b_len) begin
          rd.valid = (rand_mode == 0) || ($urandom_range(0, 3) != 0);
          rd.tdata = data_at(b_addr + 64'(b_sent) * 64'd64);
        end
        if (!b_done) begin
          case (b_mode)
            0: begin rd.rmst_done = 1'b1; rd.valid = 1'b0; end
            1: rd.rmst_done = rd.valid && (b_sent == b_len - 1);
            default: if (b_sent == b_len) begin
              if (b_delay == 0) rd.rmst_done = 1'b1;
              else b_delay--;
            end
          endcase
        end
      end
      #1;
      if (rd.rmst_req) begin
        obs_req.push_back('{addr: rd.rmst_addr, size: rd.rmst_xfer_size});
        p_addr.push_back(rd.rmst_addr);
        p_len.push_back(int'(rd.rmst_xfer_size / 64'd64));
        if (done_mode_seq.size() > 0) p_mode.push_back(done_mode_seq.pop_front());
        else p_mode.push_back((rand_mode == 0) ? 1 : int'($urandom_range(0, 2)));
      end
      if (b_act) begin
        if (!b_done && (rd.rmst_addr !== b_addr || rd.rmst_xfer_size !== 64'(b_len) * 64'd64))
          addr_unstable++;
        if (rd.valid && rd.ready) begin b_sent++; obs_beats++; end
        if (rd.rmst_done) b_done = 1;
        if (b_done && b_sent == b_len) b_act = 0;
      end
      for (int i = 0; i < NP; i++)
        if (lane_valid[i] && lane_ready[i]) obs_pop.push_back('{lane: i, data: lane_data[i*512 +: 512]});
      if (job_done) obs_done++;
    end
  endtask

  task automatic start_job(input logic [63:0] off, input int total);
    @(negedge clk);
    obs_req.delete();
    obs_pop.delete();
    obs_beats = 0;
    obs_done = 0;
    addr_unstable = 0;
    exp_off = off;
    exp_total = total;
    salt = {$urandom, $urandom};
    start = 1'b1;
    rmst_offset = off;
    total_words = 32'(total);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for job completion and lane drain; expiry counts as a failure.
  task automatic wait_job(input string name, input int budget);
    bit ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      #2;
      ok = (obs_done > 0) && (lane_valid == '0) && !busy;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: not finished after %0d cycles, done pulses %0d lane_valid %h, want done and drained",
               name, budget, obs_done, lane_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (job_done !== 1'b0) begin n_fail++; $display("FAIL reset_job_done: got %b want 0", job_done); end
    n_checks++; if (rd.rmst_req !== 1'b0) begin n_fail++; $display("FAIL reset_rmst_req: got %b want 0", rd.rmst_req); end
    n_checks++; if (rd.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", rd.ready); end
    n_checks++; if (lane_valid !== '0) begin n_fail++; $display("FAIL reset_lane_valid: got %h want 0", lane_valid); end
    n_checks++; if (rd.rmst_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", rd.rmst_addr); end
    n_checks++; if (rd.rmst_xfer_size !== '0) begin n_fail++; $display("FAIL reset_size: got %h want 0", rd.rmst_xfer_size); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int e;
    rand_mode = 0;
    start_job(64'h1000, 5);
    wait_job("basic", 200);
    n_checks++; e = req_errors();
    if (e != 0) begin n_fail++; $display("FAIL basic_requests: %0d bad, %s", e, diag); end
    n_checks++; e = lane_errors();
    if (e != 0) begin n_fail++; $display("FAIL basic_lanes: %0d bad, %s", e, diag); end
    n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL basic_job_done: got %0d pulses want 1", obs_done); end
    n_checks++; if (addr_unstable !== 0) begin n_fail++; $display("FAIL basic_addr_stable: got %0d changes want 0", addr_unstable); end
  endtask

  task automatic test_wrap();
    int e;
    rand_mode = 1;
    start_job({32'($urandom), 26'($urandom), 6'b0}, 60);
    wait_job("wrap", 2000);
    n_checks++; e = req_errors();
    if (e != 0) begin n_fail++; $display("FAIL wrap_requests: %0d bad, %s", e, diag); end
    n_checks++; e = lane_errors();
    if (e != 0) begin n_fail++; $display("FAIL wrap_lanes: %0d bad, %s", e, diag); end
    n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL wrap_job_done: got %0d pulses want 1", obs_done); end
    n_checks++; if (addr_unstable !== 0) begin n_fail++; $display("FAIL wrap_addr_stable: got %0d changes want 0", addr_unstable); end
  endtask

  task automatic test_stall();
    int e;
    rand_mode = 0;
    hold_mask = NP'(1) << 1;
    start_job(64'h4_0000, 40);
    for (int c = 0; c < 500 && obs_beats < 29; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    #2;
    n_checks++; if (obs_beats !== 29) begin n_fail++; $display("FAIL stall_beats: got %0d accepted want 29", obs_beats); end
    n_checks++; if (rd.ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b want 0", rd.ready); end
    n_checks++; if (lane_valid[1] !== 1'b1) begin n_fail++; $display("FAIL stall_lane1_full: got %b want 1", lane_valid[1]); end
    hold_mask = '0;
    wait_job("stall", 500);
    n_checks++; e = req_errors();
    if (e != 0) begin n_fail++; $display("FAIL stall_requests: %0d bad, %s", e, diag); end
    n_checks++; e = lane_errors();
    if (e != 0) begin n_fail++; $display("FAIL stall_lanes: %0d bad, %s", e, diag); end
    n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL stall_job_done: got %0d pulses want 1", obs_done); end
  endtask

  task automatic test_done_timing();
    int e;
    rand_mode = 0;
    done_mode_seq = '{0, 1, 0, 1, 2};
    start_job(64'h8000, 10);
    wait_job("done_timing", 300);
    n_checks++; e = req_errors();
    if (e != 0) begin n_fail++; $display("FAIL done_timing_requests: %0d bad, %s", e, diag); end
    n_checks++; e = lane_errors();
    if (e != 0) begin n_fail++; $display("FAIL done_timing_lanes: %0d bad, %s", e, diag); end
    n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL done_timing_job_done: got %0d pulses want 1", obs_done); end
    n_checks++; if (addr_unstable !== 0) begin n_fail++; $display("FAIL done_timing_addr_stable: got %0d changes want 0", addr_unstable); end
  endtask

  task automatic test_zero_and_busy();
    int e;
    rand_mode = 0;
    @(negedge clk);
    obs_req.delete();
    obs_done = 0;
    start = 1'b1;
    rmst_offset = 64'h5000;
    total_words = '0;
    @(negedge clk);
    start = 1'b0;
    #2;
    n_checks++; if (job_done !== 1'b1) begin n_fail++; $display("FAIL zero_job_done: got %b want 1", job_done); end
    @(negedge clk);
    #2;
    n_checks++; if (job_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_after: job_done %b busy %b want 0 0", job_done, busy);
    end
    repeat (4) @(negedge clk);
    n_checks++; if (obs_req.size() !== 0) begin n_fail++; $display("FAIL zero_no_req: got %0d requests want 0", obs_req.size()); end
    n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL zero_pulses: got %0d pulses want 1", obs_done); end

    start_job(64'h2000, 10);
    repeat (3) @(negedge clk);
    start = 1'b1;
    rmst_offset = 64'h9000;
    total_words = 32'd4;
    @(negedge clk);
    start = 1'b0;
    wait_job("busy_start", 300);
    n_checks++; e = req_errors();
    if (e != 0) begin n_fail++; $display("FAIL busy_start_requests: %0d bad, %s", e, diag); end
    n_checks++; e = lane_errors();
    if (e != 0) begin n_fail++; $display("FAIL busy_start_lanes: %0d bad, %s", e, diag); end
    n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL busy_start_job_done: got %0d pulses want 1", obs_done); end
  endtask

  task automatic test_random();
    int e;
    rand_mode = 1;
    for (int t = 0; t < 6; t++) begin
      start_job({32'($urandom), 26'($urandom), 6'b0}, int'($urandom_range(1, 70)));
      wait_job("random", 3000);
      n_checks++; e = req_errors();
      if (e != 0) begin n_fail++; $display("FAIL random%0d_requests: %0d bad, %s", t, e, diag); end
      n_checks++; e = lane_errors();
      if (e != 0) begin n_fail++; $display("FAIL random%0d_lanes: %0d bad, %s", t, e, diag); end
      n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL random%0d_job_done: got %0d pulses want 1", t, obs_done); end
      n_checks++; if (addr_unstable !== 0) begin n_fail++; $display("FAIL random%0d_addr_stable: got %0d changes want 0", t, addr_unstable); end
    end
  endtask

  task automatic test_reset_mid();
    int e;
    rand_mode = 0;
    start_job(64'h1000, 5);
    for (int c = 0; c < 100 && obs_beats < 2; c++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if (job_done !== 1'b0) begin n_fail++; $display("FAIL midrst_job_done: got %b want 0", job_done); end
    n_checks++; if (rd.rmst_req !== 1'b0) begin n_fail++; $display("FAIL midrst_rmst_req: got %b want 0", rd.rmst_req); end
    n_checks++; if (rd.ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", rd.ready); end
    n_checks++; if (lane_valid !== '0) begin n_fail++; $display("FAIL midrst_lane_valid: got %h want 0", lane_valid); end
    n_checks++; if (rd.rmst_addr !== '0) begin n_fail++; $display("FAIL midrst_addr: got %h want 0", rd.rmst_addr); end
    n_checks++; if (rd.rmst_xfer_size !== '0) begin n_fail++; $display("FAIL midrst_size: got %h want 0", rd.rmst_xfer_size); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_job(64'h1000, 5);
    wait_job("replay", 200);
    n_checks++; e = req_errors();
    if (e != 0) begin n_fail++; $display("FAIL replay_requests: %0d bad, %s", e, diag); end
    n_checks++; e = lane_errors();
    if (e != 0) begin n_fail++; $display("FAIL replay_lanes: %0d bad, %s", e, diag); end
    n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL replay_job_done: got %0d pulses want 1", obs_done); end
  endtask

  initial begin
    rd.valid = 1'b0;
    rd.rmst_done = 1'b0;
    rd.tdata = '0;
    lane_ready = '1;
    fork
      bus_model();
    join_none
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_done_timing();
    test_zero_and_busy();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
